nba_round_sched: RTL and testbench

- Hardware round sequencer for the number-baseball accelerator. It runs NUM_ROUND games back-to-back on one solver/grader pair.
- Per round it fetches the secret answer from an answer memory, drives it to the grader, and holds the solver/grader pair in game reset for a fixed window.
- It then waits for `correct` or the try limit, and records per-round and aggregate try counts.
- It replaces the software round loop so full benchmark runs execute in hardware.

---
 rtl/nba_round_sched.sv | 172 +++++++++++++++++
 tb/tb_nba_round_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nba_round_sched.sv
// nba_round_sched: runs NUM_ROUND number-baseball games back-to-back in hardware.
// Define NBA_SCHED_STATS_EN to track per-run max/min try counts.
module nba_round_sched #(
  parameter int NUM_ROUND = 1024,
  parameter int ADDR_W    = 10,
  parameter int MAX_TRY   = 200,
  parameter int RST_CYC   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ans_rd,
  output logic [ADDR_W-1:0] ans_addr,
  input  logic [15:0]       ans_rdata,
  output logic [15:0]       answer,
  output logic              game_rst_n,
  input  logic              correct,
  input  logic [15:0]       cnt,
  output logic [ADDR_W-1:0] round_idx,
  output logic              rec_valid,
  output logic [15:0]       rec_cnt,
  output logic              rec_timeout,
  output logic              busy,
  output logic              done,
  output logic [31:0]       total_cnt,
  output logic [ADDR_W:0]   timeout_cnt,
  output logic [15:0]       max_cnt,
  output logic [15:0]       min_cnt
);
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ROUND - 1);
  localparam logic [15:0] MAXT = 16'(MAX_TRY);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_RESTART, S_PLAY, S_RECORD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] round_q, round_d;
  logic [15:0]       answer_q, answer_d;
  logic [15:0]       rec_cnt_q, rec_cnt_d;
  logic              rec_to_q, rec_to_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;
  logic [31:0]       total_q, total_d;
  logic [ADDR_W:0]   tocnt_q, tocnt_d;
  logic [32:0]       sum;
  logic              run_start;

  assign run_start = start && (state_q == S_IDLE || state_q == S_DONE);
  assign sum = {1'b0, total_q} + {17'd0, rec_cnt_q};

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    answer_d  = answer_q;
    rec_cnt_d = rec_cnt_q;
    rec_to_d  = rec_to_q;
    rcnt_d    = rcnt_q;
    total_d   = total_q;
    tocnt_d   = tocnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          round_d = '0;
          total_d = '0;
          tocnt_d = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        answer_d = ans_rdata;
        rcnt_d   = RW'(RST_CYC - 1);
        state_d  = S_RESTART;
      end
      S_RESTART: begin
        if (rcnt_q == '0) state_d = S_PLAY;
        else rcnt_d = rcnt_q - 1'b1;
      end
      S_PLAY: begin
        // correct wins over a simultaneous try-limit hit
        if (correct) begin
          rec_cnt_d = cnt;
          rec_to_d  = 1'b0;
          state_d   = S_RECORD;
        end else if (cnt >= MAXT) begin
          rec_cnt_d = MAXT;
          rec_to_d  = 1'b1;
          state_d   = S_RECORD;
        end
      end
      S_RECORD: begin
        total_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        tocnt_d = tocnt_q + {ADDR_W'(0), rec_to_q};
        if (round_q == LAST) begin
          state_d = S_DONE;
        end else begin
          round_d = round_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      answer_q  <= '0;
      rec_cnt_q <= '0;
      rec_to_q  <= 1'b0;
      rcnt_q    <= '0;
      total_q   <= '0;
      tocnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      answer_q  <= answer_d;
      rec_cnt_q <= rec_cnt_d;
      rec_to_q  <= rec_to_d;
      rcnt_q    <= rcnt_d;
      total_q   <= total_d;
      tocnt_q   <= tocnt_d;
    end
  end

`ifdef NBA_SCHED_STATS_EN
  logic [15:0] max_q, max_d, min_q, min_d;

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (run_start) begin
      max_d = '0;
      min_d = '1;
    end else if (state_q == S_RECORD) begin
      if (rec_cnt_q > max_q) max_d = rec_cnt_q;
      if (rec_cnt_q < min_q) min_d = rec_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q <= '0;
      min_q <= '1;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign max_cnt = max_q;
  assign min_cnt = min_q;
`else
  assign max_cnt = '0;
  assign min_cnt = '1;
`endif

  assign ans_rd      = (state_q == S_FETCH);
  assign ans_addr    = round_q;
  assign answer      = answer_q;
  assign game_rst_n  = (state_q == S_PLAY);
  assign round_idx   = round_q;
  assign rec_valid   = (state_q == S_RECORD);
  assign rec_cnt     = rec_cnt_q;
  assign rec_timeout = rec_to_q && (state_q == S_RECORD);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign total_cnt   = total_q;
  assign timeout_cnt = tocnt_q;
endmodule

// File: tb/tb_nba_round_sched.sv
// Bench for nba_round_sched: 4-round runs with a counting grader model,
// directed corner cases and randomized targets against a run-level model.
module tb_nba_round_sched;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int MT = 200;
  localparam int RC = 3;

  logic          clk = 0;
  logic          reset = 0;
  logic          start = 0;
  logic          ans_rd;
  logic [AW-1:0] ans_addr;
  logic [15:0]   ans_rdata = 0;
  logic [15:0]   answer;
  logic          game_rst_n;
  logic          correct;
  logic [15:0]   cnt = 0;
  logic [AW-1:0] round_idx;
  logic          rec_valid;
  logic [15:0]   rec_cnt;
  logic          rec_timeout;
  logic          busy;
  logic          done;
  logic [31:0]   total_cnt;
  logic [AW:0]   timeout_cnt;
  logic [15:0]   max_cnt;
  logic [15:0]   min_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [NR];
  logic [15:0] tgt [NR];

  int addr_q[$];
  int ans_q[$];
  int rc_q[$];
  int rt_q[$];
  int gap_q[$];
  bit ans_moved;

  nba_round_sched #(
    .NUM_ROUND(NR), .ADDR_W(AW), .MAX_TRY(MT), .RST_CYC(RC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ans_rd(ans_rd), .ans_addr(ans_addr), .ans_rdata(ans_rdata),
    .answer(answer), .game_rst_n(game_rst_n),
    .correct(correct), .cnt(cnt), .round_idx(round_idx),
    .rec_valid(rec_valid), .rec_cnt(rec_cnt),
    .rec_timeout(rec_timeout), .busy(busy), .done(done),
    .total_cnt(total_cnt), .timeout_cnt(timeout_cnt),
    .max_cnt(max_cnt), .min_cnt(min_cnt)
  );

  always #5 clk = ~clk;

  // answer memory: one-cycle read latency
  always @(posedge clk) if (ans_rd) ans_rdata <= mem[ans_addr[1:0]];

  // grader: counts tries from game start, correct when it hits the target
  always @(posedge clk or negedge reset) begin
    if (!reset) cnt <= 0;
    else if (!game_rst_n) cnt <= 0;
    else cnt <= cnt + 1;
  end
  assign correct = game_rst_n && (cnt == tgt[round_idx[1:0]]);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, "_rd"}, ans_rd, 0);
    chk({t, "_addr"}, ans_addr, 0);
    chk({t, "_ans"}, answer, 0);
    chk({t, "_grst"}, game_rst_n, 0);
    chk({t, "_ridx"}, round_idx, 0);
    chk({t, "_rv"}, rec_valid, 0);
    chk({t, "_rto"}, rec_timeout, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_tot"}, total_cnt, 0);
    chk({t, "_tocnt"}, timeout_cnt, 0);
    chk({t, "_max"}, max_cnt, 0);
    chk({t, "_min"}, min_cnt, 16'hFFFF);
  endtask

  task automatic run(input bit mid_start, input bit abort);
    int since_rd;
    bit prev_g, pend_end, rv_prev, did;
    logic [15:0] held;
    addr_q.delete(); ans_q.delete(); rc_q.delete();
    rt_q.delete(); gap_q.delete();
    ans_moved = 0;
    since_rd = -1; prev_g = 0; pend_end = 0; rv_prev = 0; did = 0;
    held = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("start_lat", ans_rd, 1);
    for (int c = 0; c < 5000 && !done; c++) begin
      if (pend_end) chk("end2rec", rec_valid, 1);
      if (rv_prev) chk("rec2rd", ans_rd, 1);
      if (ans_rd) begin
        addr_q.push_back(int'(ans_addr));
        since_rd = 0;
      end else if (since_rd >= 0) begin
        since_rd++;
      end
      if (game_rst_n && !prev_g) begin
        gap_q.push_back(since_rd);
        ans_q.push_back(int'(answer));
        held = answer;
      end
      if (game_rst_n && answer !== held) ans_moved = 1;
      if (rec_valid) begin
        rc_q.push_back(int'(rec_cnt));
        rt_q.push_back(int'(rec_timeout));
      end
      pend_end = game_rst_n && (correct || cnt >= MT);
      rv_prev = rec_valid;
      prev_g = game_rst_n;
      if (abort && game_rst_n && round_idx == 2) begin
        reset = 0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        reset = 1;
        return;
      end
      if (mid_start && !did && game_rst_n && round_idx == 2) begin
        start = 1;
        did = 1;
      end else begin
        start = 0;
      end
      @(negedge clk);
    end
    start = 0;
    chk("done_wait", done, 1);
  endtask

  task automatic verify(input string t);
    longint sum = 0;
    int to = 0, mx = 0, mn = 16'hFFFF, ec, et;
    chk({t, "_nrec"}, rc_q.size(), NR);
    chk({t, "_nrd"}, addr_q.size(), NR);
    chk({t, "_ngame"}, gap_q.size(), NR);
    for (int i = 0; i < NR; i++) begin
      et = (tgt[i] > MT) ? 1 : 0;
      ec = et ? MT : int'(tgt[i]);
      sum += ec;
      to += et;
      if (ec > mx) mx = ec;
      if (ec < mn) mn = ec;
      if (i < addr_q.size()) chk($sformatf("%s_addr%0d", t, i), addr_q[i], i);
      if (i < ans_q.size()) chk($sformatf("%s_ans%0d", t, i), ans_q[i], mem[i]);
      if (i < gap_q.size()) chk($sformatf("%s_gap%0d", t, i), gap_q[i], 2 + RC);
      if (i < rc_q.size()) chk($sformatf("%s_rc%0d", t, i), rc_q[i], ec);
      if (i < rt_q.size()) chk($sformatf("%s_rt%0d", t, i), rt_q[i], et);
    end
    chk({t, "_tot"}, total_cnt, 32'(sum));
    chk({t, "_tocnt"}, timeout_cnt, to);
    chk({t, "_done"}, done, 1);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_ridx"}, round_idx, NR - 1);
    chk({t, "_grst"}, game_rst_n, 0);
    chk({t, "_stable"}, ans_moved, 0);
`ifdef NBA_SCHED_STATS_EN
    chk({t, "_max"}, max_cnt, mx);
    chk({t, "_min"}, min_cnt, mn);
`else
    chk({t, "_max"}, max_cnt, 0);
    chk({t, "_min"}, min_cnt, 16'hFFFF);
`endif
  endtask

  initial begin
    mem[0] = 16'h0123; mem[1] = 16'h4567;
    mem[2] = 16'h89AB; mem[3] = 16'hCDEF;
    tgt[0] = 5; tgt[1] = 7; tgt[2] = 3; tgt[3] = 9;
    #1;
    check_reset("rst");
    #20;
    @(negedge clk); reset = 1;

    run(0, 0);
    verify("basic");

    tgt[0] = 4; tgt[1] = 16'hFFFF; tgt[2] = 6; tgt[3] = 200;
    run(1, 0);
    verify("tmo");

    tgt[0] = 11; tgt[1] = 2; tgt[2] = 16'hFFFF; tgt[3] = 8;
    run(0, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    run(0, 0);
    verify("restart");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NR; i++) begin
        mem[i] = 16'($urandom);
        tgt[i] = 16'($urandom_range(1, 210));
      end
      run(0, 0);
      verify($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
